axi_rd_txn_guard: RTL and testbench

Parametrised read-channel transaction guard: successor to the single-instance slave guard, generalised to a configurable outstanding-transaction table with per-ID in-order tracking and per-transaction latency budgets. Passively taps AR/R handshakes between a manager and a slave, times every outstanding read burst, and raises an interrupt plus a reset request when any burst exceeds its budget. Sits beside the existing guard in the monitor wrapper and is purely observational; it never drives AXI signals.

---
 rtl/axi_rd_txn_guard_if.sv | 16 +
 rtl/axi_rd_txn_guard.sv | 168 ++++++++++++++++
 tb/tb_axi_rd_txn_guard.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_txn_guard_if.sv
// Passive tap of one AXI read channel: AR/R handshakes, IDs and the R last beat.
// The guard connects through the slave modport and only ever reads these signals.
interface axi_rd_txn_guard_if #(
    parameter int AxiIdWidth = 4
);
    logic                  ar_valid;
    logic                  ar_ready;
    logic [AxiIdWidth-1:0] ar_id;
    logic                  r_valid;
    logic                  r_ready;
    logic                  r_last;
    logic [AxiIdWidth-1:0] r_id;

    modport master (output ar_valid, ar_ready, ar_id, r_valid, r_ready, r_last, r_id);
    modport slave  (input  ar_valid, ar_ready, ar_id, r_valid, r_ready, r_last, r_id);
endinterface

// File: rtl/axi_rd_txn_guard.sv
// Read-channel transaction guard: times every outstanding read burst and raises irq/reset request on timeout.
// Define RD_GUARD_HWM_EN to build the latency high-watermark register behind hwm_o (tied to 0 otherwise).
module axi_rd_txn_guard #(
    parameter int AxiIdWidth = 4,
    parameter int MaxTxns    = 8,
    parameter int CntWidth   = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  guard_ena_i,
    axi_rd_txn_guard_if.slave     tap,
    input  logic [CntWidth-1:0]   budget_i,
    input  logic                  irq_clr_i,
    input  logic                  rst_stat_i,
    output logic                  irq_o,
    output logic                  rst_req_o,
    output logic [AxiIdWidth-1:0] fault_id_o,
    output logic                  err_overflow_o,
    output logic                  err_unexp_o,
    output logic [CntWidth-1:0]   hwm_o
);
    localparam int IdxW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]            state_q;
    logic [MaxTxns-1:0]    valid_q;
    logic [AxiIdWidth-1:0] id_q      [MaxTxns];
    logic [CntWidth-1:0]   elapsed_q [MaxTxns];

    logic                  irq_q;
    logic [AxiIdWidth-1:0] fault_id_q;
    logic                  overflow_q;
    logic                  unexp_q;

    logic                  ar_hs;
    logic                  r_last_hs;
    logic                  flush;
    logic                  active;
    logic                  free_hit;
    logic [IdxW-1:0]       free_idx;
    logic [CntWidth-1:0]   free_elapsed;
    logic                  alloc_ok;
    logic [IdxW-1:0]       alloc_idx;
    logic                  fault_any;
    logic [AxiIdWidth-1:0] fault_id;
    logic                  fault_take;

    assign ar_hs     = tap.ar_valid & tap.ar_ready;
    assign r_last_hs = tap.r_valid & tap.r_ready & tap.r_last;
    // Leaving WAIT empties the table; that cycle behaves like a disabled guard.
    assign flush     = (state_q == WAIT) && !rst_stat_i;
    assign active    = guard_ena_i && !flush;

    // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        free_hit     = 1'b0;
        free_idx     = '0;
        free_elapsed = '0;
        alloc_ok     = 1'b0;
        alloc_idx    = '0;
        fault_any    = 1'b0;
        fault_id     = '0;
        // Oldest matching entry: strictly larger elapsed replaces, so ties keep the lowest index.
        for (int i = 0; i < MaxTxns; i++) begin
            if (r_last_hs && valid_q[i] && id_q[i] == tap.r_id &&
                (!free_hit || elapsed_q[i] > free_elapsed)) begin
                free_hit     = 1'b1;
                free_idx     = IdxW'(i);
                free_elapsed = elapsed_q[i];
            end
        end
        // Descending scan so the lowest free / lowest faulting index is the last one written.
        for (int i = MaxTxns - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_ok  = 1'b1;
                alloc_idx = IdxW'(i);
            end
            if (valid_q[i] && budget_i != '0 && elapsed_q[i] >= budget_i &&
                !(free_hit && free_idx == IdxW'(i))) begin
                fault_any = 1'b1;
                fault_id  = id_q[i];
            end
        end
    end

    assign fault_take = active && fault_any && (!irq_q || irq_clr_i);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            // NOTE: the table is plain flops, reset with valid_q so no X ever reaches the compare logic.
            for (int i = 0; i < MaxTxns; i++) begin
                id_q[i]      <= '0;
                elapsed_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MaxTxns; i++) begin
                if (valid_q[i] && elapsed_q[i] != '1) elapsed_q[i] <= elapsed_q[i] + 1'b1;
            end
            if (!active) begin
                valid_q <= '0;
            end else begin
                if (free_hit) valid_q[free_idx] <= 1'b0;
                if (ar_hs && alloc_ok) begin
                    valid_q[alloc_idx]   <= 1'b1;
                    id_q[alloc_idx]      <= tap.ar_id;
                    elapsed_q[alloc_idx] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            irq_q      <= 1'b0;
            fault_id_q <= '0;
            overflow_q <= 1'b0;
            unexp_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (fault_take)  state_q <= REQ;
                REQ:     if (rst_stat_i)  state_q <= WAIT;
                WAIT:    if (!rst_stat_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (fault_take) begin
                irq_q      <= 1'b1;
                fault_id_q <= fault_id;
            end else if (irq_clr_i) begin
                irq_q      <= 1'b0;
                fault_id_q <= '0;
            end
            if (active && ar_hs && !alloc_ok) overflow_q <= 1'b1;
            else if (irq_clr_i)               overflow_q <= 1'b0;
            if (active && r_last_hs && !free_hit) unexp_q <= 1'b1;
            else if (irq_clr_i)                   unexp_q <= 1'b0;
        end
    end

`ifdef RD_GUARD_HWM_EN
    logic [CntWidth-1:0] hwm_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hwm_q <= '0;
        end else if (irq_clr_i) begin
            hwm_q <= '0;
        end else if (active && free_hit && free_elapsed > hwm_q) begin
            hwm_q <= free_elapsed;
        end
    end

    assign hwm_o = hwm_q;
`else
    assign hwm_o = '0;
`endif

    assign irq_o          = irq_q;
    assign rst_req_o      = (state_q == REQ);
    assign fault_id_o     = fault_id_q;
    assign err_overflow_o = overflow_q;
    assign err_unexp_o    = unexp_q;
endmodule

// File: tb/tb_axi_rd_txn_guard.sv
// Scoreboard bench for axi_rd_txn_guard: a timestamp-based reference model pushes the expected
// state after every clock edge, and a monitor pops and compares it on the following falling edge.
`timescale 1ns/1ps
module tb_axi_rd_txn_guard;
    localparam int ID_W = 4;
    localparam int MAXT = 8;
    localparam int CW   = 10;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ena;
    logic            irq_clr;
    logic            rst_stat;
    logic [CW-1:0]   budget;
    logic            irq;
    logic            rst_req;
    logic [ID_W-1:0] fid;
    logic            ovf;
    logic            unexp;
    logic [CW-1:0]   hwm;

    axi_rd_txn_guard_if #(.AxiIdWidth(ID_W)) tap_if ();

    axi_rd_txn_guard #(.AxiIdWidth(ID_W), .MaxTxns(MAXT), .CntWidth(CW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .guard_ena_i    (ena),
        .tap            (tap_if),
        .budget_i       (budget),
        .irq_clr_i      (irq_clr),
        .rst_stat_i     (rst_stat),
        .irq_o          (irq),
        .rst_req_o      (rst_req),
        .fault_id_o     (fid),
        .err_overflow_o (ovf),
        .err_unexp_o    (unexp),
        .hwm_o          (hwm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                     irq;
        logic                     rst_req;
        logic                     ovf;
        logic                     unexp;
        logic [ID_W-1:0]          fid;
        logic [CW-1:0]            hwm;
        logic [MAXT-1:0]          valid;
        logic [MAXT-1:0][CW-1:0]  el;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    event chk_ev;

    // Reference model: each transaction remembers the cycle it became visible; its age is derived.
    bit              m_valid [MAXT];
    logic [ID_W-1:0] m_id    [MAXT];
    int              m_born  [MAXT];
    int              cyc = 0;
    bit              m_irq, m_ovf, m_unexp;
    logic [ID_W-1:0] m_fid;
    int              m_hwm;
    int              m_phase;  // 0 idle, 1 requesting reset, 2 waiting for reset to finish

    function automatic int age(int i);
        int e = cyc - m_born[i];
        return (e > CMAX) ? CMAX : e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < MAXT; i++) m_valid[i] = 1'b0;
        m_irq = 0; m_ovf = 0; m_unexp = 0; m_fid = '0; m_hwm = 0; m_phase = 0;
    endfunction

    function automatic void model_step();
        bit ar, rl, flush, act, take;
        int fi, ft, ai;
        if (!rst_n) begin
            model_reset();
            cyc++;
            return;
        end
        ar    = tap_if.ar_valid && tap_if.ar_ready;
        rl    = tap_if.r_valid && tap_if.r_ready && tap_if.r_last;
        flush = (m_phase == 2) && !rst_stat;
        act   = ena && !flush;
        fi = -1; ft = -1; ai = -1;
        for (int i = 0; i < MAXT; i++)
            if (rl && m_valid[i] && m_id[i] == tap_if.r_id && (fi < 0 || age(i) > age(fi))) fi = i;
        for (int i = 0; i < MAXT; i++)
            if (ft < 0 && m_valid[i] && budget != 0 && age(i) >= int'(budget) && i != fi) ft = i;
        for (int i = 0; i < MAXT; i++)
            if (ai < 0 && !m_valid[i]) ai = i;
        take = act && ft >= 0 && (!m_irq || irq_clr);
        if (m_phase == 0 && take)           m_phase = 1;
        else if (m_phase == 1 && rst_stat)  m_phase = 2;
        else if (m_phase == 2 && !rst_stat) m_phase = 0;
        if (take) begin
            m_irq = 1; m_fid = m_id[ft];
        end else if (irq_clr) begin
            m_irq = 0; m_fid = '0;
        end
        if (act && ar && ai < 0) m_ovf = 1;
        else if (irq_clr)        m_ovf = 0;
        if (act && rl && fi < 0) m_unexp = 1;
        else if (irq_clr)        m_unexp = 0;
`ifdef RD_GUARD_HWM_EN
        if (irq_clr)                              m_hwm = 0;
        else if (act && fi >= 0 && age(fi) > m_hwm) m_hwm = age(fi);
`endif
        if (!act) begin
            for (int i = 0; i < MAXT; i++) m_valid[i] = 1'b0;
        end else begin
            if (fi >= 0) m_valid[fi] = 1'b0;
            if (ar && ai >= 0) begin
                m_valid[ai] = 1'b1;
                m_id[ai]    = tap_if.ar_id;
                m_born[ai]  = cyc + 1;
            end
        end
        cyc++;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e         = '0;
        e.irq     = m_irq;
        e.rst_req = (m_phase == 1);
        e.ovf     = m_ovf;
        e.unexp   = m_unexp;
        e.fid     = m_fid;
        e.hwm     = CW'(m_hwm);
        for (int i = 0; i < MAXT; i++) begin
            if (m_valid[i]) begin
                e.valid[i] = 1'b1;
                e.el[i]    = CW'(age(i));
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT state against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("irq",       irq,         e.irq);
                check("rst_req",   rst_req,     e.rst_req);
                check("fault_id",  fid,         e.fid);
                check("overflow",  ovf,         e.ovf);
                check("unexp",     unexp,       e.unexp);
                check("hwm",       hwm,         e.hwm);
                check("valid_map", dut.valid_q, e.valid);
                for (int i = 0; i < MAXT; i++)
                    if (e.valid[i]) check("elapsed", dut.elapsed_q[i], e.el[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        exp_q.push_back(snap());
        #1;
    endtask

    task automatic step();
        tick();
        tap_if.ar_valid = 0; tap_if.ar_ready = 0;
        tap_if.r_valid  = 0; tap_if.r_ready  = 0; tap_if.r_last = 0;
        irq_clr = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic ar(input logic [ID_W-1:0] id);
        tap_if.ar_valid = 1; tap_if.ar_ready = 1; tap_if.ar_id = id;
    endtask

    task automatic rl(input logic [ID_W-1:0] id);
        tap_if.r_valid = 1; tap_if.r_ready = 1; tap_if.r_last = 1; tap_if.r_id = id;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1;
        rst_n = 0;
        model_reset();
        exp_q.push_back(snap());
        #1;
        ->chk_ev;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hold;
        rst_n = 0; ena = 1; irq_clr = 0; rst_stat = 0; budget = '0;
        tap_if.ar_valid = 0; tap_if.ar_ready = 0; tap_if.ar_id = '0;
        tap_if.r_valid  = 0; tap_if.r_ready  = 0; tap_if.r_last = 0; tap_if.r_id = '0;
        model_reset();
        exp_q.push_back(snap());
        @(negedge clk);
        #1;
        rst_n = 1;

        // Basic read completing within budget.
        budget = CW'(20);
        ar(3); step();
        idle(9);
        rl(3); step();
        idle(2);

        // Timeout, reset handshake and flush on leaving WAIT.
        budget = CW'(5);
        ar(2); step();
        idle(8);
        rst_stat = 1; idle(3);
        rst_stat = 0; idle(3);
        irq_clr = 1; step();

        // Same ID twice: the older one is freed first.
        budget = '0;
        ar(1); step();
        step();
        ar(1); step();
        step();
        rl(1); step();
        step();
        rl(1); step();

        // Overflow with a full table, then clear and flush.
        repeat (9) begin ar(5); step(); end
        step();
        irq_clr = 1; step();
        ena = 0; step();
        ena = 1;

        // Free in the exact cycle elapsed reaches the budget, then an unexpected R last.
        budget = CW'(4);
        ar(6); step();
        idle(4);
        rl(6); step();
        rl(7); step();
        step();
        irq_clr = 1; step();

        // Disable with outstanding entries and a budget they already exceed.
        budget = '0;
        ar(1); step();
        ar(2); step();
        ar(3); step();
        step();
        budget = CW'(2); ena = 0; step();
        idle(5);
        ena = 1; budget = '0;

        // Asynchronous reset mid-operation.
        ar(4); step();
        ar(5); step();
        step();
        async_reset();
        step();
        rst_n = 1;
        idle(2);

        // Randomised traffic with a reset controller answering the request.
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            ena = ($urandom_range(0, 99) != 0);
            if (n % 150 == 0)
                budget = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(3, 40));
            tap_if.ar_valid = ($urandom_range(0, 2) == 0);
            tap_if.ar_ready = ($urandom_range(0, 3) != 0);
            tap_if.ar_id    = ID_W'($urandom_range(0, 3));
            tap_if.r_valid  = ($urandom_range(0, 2) == 0);
            tap_if.r_ready  = ($urandom_range(0, 3) != 0);
            tap_if.r_last   = ($urandom_range(0, 1) == 0);
            tap_if.r_id     = ID_W'($urandom_range(0, 4));
            irq_clr         = ($urandom_range(0, 29) == 0);
            if (hold > 0) begin
                rst_stat = 1;
                hold--;
            end else begin
                rst_stat = 0;
                if (m_phase == 1 && $urandom_range(0, 3) == 0) hold = $urandom_range(1, 3);
            end
            step();
        end
        rst_stat = 0;
        idle(3);

        @(negedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
